// File: rtl/alu_result_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo_pkg
// Brief    : Shared widths, default Q-format and saturation bounds for the
//            ALU result path and its requantizing consumers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_result_fifo_pkg;

  // ALU result width and narrowed operand width
  localparam int RES_W = 16;
  localparam int OPW   = 8;

  // Default fractional bits of the 8-bit operand format
  localparam int FRAC_BITS_DEFAULT = 4;

  // Saturation bounds of the 8-bit signed operand format
  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

  typedef logic signed [RES_W-1:0] result_t;
  typedef logic signed [OPW-1:0]   operand_t;

endpackage : alu_result_fifo_pkg
`default_nettype wire

// File: rtl/fixed_point_requant.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_requant
// Brief    : Combinational round-shift-saturate narrowing of a 16-bit signed
//            ALU result to the 8-bit signed operand format.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_requant
  import alu_result_fifo_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic    [RES_W-1:0] res_i,
  input  logic                scale_i,
  output logic    [OPW-1:0]   data_o,
  output logic                sat_o
);

  // One extra bit so the rounding add on the most positive result cannot wrap
  localparam logic signed [RES_W:0] c_HALF = (RES_W+1)'(1 << (FRAC_BITS - 1));
  localparam logic signed [RES_W:0] c_MAX  = (RES_W+1)'(Q_MAX);
  localparam logic signed [RES_W:0] c_MIN  = (RES_W+1)'(Q_MIN);

  logic signed [RES_W:0] w_ext;
  logic signed [RES_W:0] w_rnd;
  logic signed [RES_W:0] w_val;
  logic                  w_hi;
  logic                  w_lo;

  // Round half up on products, pass plain results through, then clamp
  always_comb begin
    w_ext = $signed({res_i[RES_W-1], res_i});
    w_rnd = w_ext + c_HALF;
    w_val = scale_i ? (w_rnd >>> FRAC_BITS) : w_ext;
    w_hi  = (w_val > c_MAX);
    w_lo  = (w_val < c_MIN);
    sat_o = w_hi | w_lo;
    if (w_hi) begin
      data_o = c_MAX[OPW-1:0];
    end else if (w_lo) begin
      data_o = c_MIN[OPW-1:0];
    end else begin
      data_o = w_val[OPW-1:0];
    end
  end

endmodule : fixed_point_requant
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Brief    : Requantizes the ALU result stream to 8 bits and buffers it in a
//            small FIFO with a valid/ready output; sticky flags report
//            saturation and results dropped while full.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RES_W-1:0]           res_i,
  input  logic                       valid_i,
  input  logic                       scale_i,
  input  logic                       ready_i,
  input  logic                       clr_flags_i,
  output logic [OPW-1:0]             data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       sat_o,
  output logic                       ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [OPW-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             sat_q,    sat_d;
  logic             ovf_q,    ovf_d;

  logic [OPW-1:0]   w_rq_data;
  logic             w_rq_sat;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  fixed_point_requant #(
    .FRAC_BITS (FRAC_BITS)
  ) u_requant (
    .res_i   (res_i),
    .scale_i (scale_i),
    .data_o  (w_rq_data),
    .sat_o   (w_rq_sat)
  );

  // Outputs come straight from registered state; no path from res_i/valid_i
  always_comb begin
    valid_o = (count_q != '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    count_o = count_q;
    sat_o   = sat_q;
    ovf_o   = ovf_q;
    data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  end

  // Handshake decode and next-state for pointers, occupancy and stickies
  always_comb begin
    w_pop    = valid_o && ready_i;
    w_push   = valid_i && (!full_o || w_pop);
    w_drop   = valid_i && full_o && !w_pop;
    wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CNT_W'(1);
    end
    // A clear loses to a same-cycle set
    sat_d = clr_flags_i ? 1'b0 : sat_q;
    ovf_d = clr_flags_i ? 1'b0 : ovf_q;
    if (w_push && w_rq_sat) begin
      sat_d = 1'b1;
    end
    if (w_drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents need no reset because data_o is masked when empty
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem_q[wr_ptr_q] <= w_rq_data;
    end
  end

endmodule : alu_result_fifo
`default_nettype wire
